// File: rtl/modu_init_ctrl.sv
// Init/strobe sequencer for one half-iteration of the sliding-window MAP decoder.
// Walks a tail-beta pass, then N windows of WIN_LEN cycles, then a one-cycle drain.
module modu_init_ctrl #(
    parameter int WIN_LEN  = 32,
    parameter int TAIL_LEN = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] q_up,
    input  logic       decMode,
    output logic       FPU_Init_Req,
    output logic       BPU_Init_Req,
    output logic       Updata_BPUtail_beta,
    output logic       Updata_BPUtail_beta_delay,
    output logic       Updata_BPU_beta,
    output logic       Updata_FPU_alpha,
    output logic       Updata_FPU_alpha_delay,
    output logic [4:0] win_idx,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE,
        TAIL,
        RUN,
        DRAIN
    } state_e;

    localparam logic [5:0] CYC_LAST  = 6'(WIN_LEN - 1);
    localparam logic [3:0] TAIL_LAST = 4'(TAIL_LEN - 1);

    state_e     state_q, state_d;
    logic [3:0] tail_q, tail_d;
    logic [5:0] cyc_q, cyc_d;
    logic [4:0] win_q, win_d;
    logic [5:0] n_q, n_d;
    logic [5:0] n_calc;

    logic       fpu_init_d, bpu_init_d;
    logic       tail_beta_d, tail_dly_d;
    logic       bpu_beta_d, fpu_alpha_d;
    logic       fin_d;
    logic [4:0] win_out_d;
    logic       last_win_d;

    // Window count in 6 bits so 2*(15+1)=32 is representable.
    assign n_calc = decMode ? ({1'b0, q_up, 1'b0} + 6'd2)
                            : ({2'b00, q_up} + 6'd1);

    always_comb begin
        state_d = state_q;
        tail_d  = tail_q;
        cyc_d   = cyc_q;
        win_d   = win_q;
        n_d     = n_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = TAIL;
                    tail_d  = 4'd0;
                    cyc_d   = 6'd0;
                    win_d   = 5'd0;
                    n_d     = n_calc;
                end
            end
            TAIL: begin
                if (tail_q == TAIL_LAST) begin
                    state_d = RUN;
                    cyc_d   = 6'd0;
                    win_d   = 5'd0;
                end else begin
                    tail_d = tail_q + 4'd1;
                end
            end
            RUN: begin
                if (cyc_q == CYC_LAST) begin
                    cyc_d = 6'd0;
                    if ({1'b0, win_q} == n_q - 6'd1) begin
                        state_d = DRAIN;
                        win_d   = 5'd0;
                    end else begin
                        win_d = win_q + 5'd1;
                    end
                end else begin
                    cyc_d = cyc_q + 6'd1;
                end
            end
            DRAIN: begin
                state_d = IDLE;
                tail_d  = 4'd0;
                cyc_d   = 6'd0;
                win_d   = 5'd0;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from next state so they land registered in the cycle they describe.
    always_comb begin
        last_win_d  = ({1'b0, win_d} == n_d - 6'd1);
        tail_beta_d = (state_d == TAIL) && (tail_d == TAIL_LAST);
        fpu_init_d  = (state_d == RUN) && (win_d == 5'd0) && (cyc_d == 6'd0);
        bpu_init_d  = (state_d == RUN) && (cyc_d == 6'd1);
        bpu_beta_d  = (state_d == RUN) && (cyc_d == CYC_LAST);
        tail_dly_d  = bpu_beta_d && (win_d == 5'd0);
        fpu_alpha_d = bpu_beta_d && last_win_d;
        fin_d       = (state_d == DRAIN);
        win_out_d   = (state_d == RUN) ? win_d : 5'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q                   <= IDLE;
            tail_q                    <= 4'd0;
            cyc_q                     <= 6'd0;
            win_q                     <= 5'd0;
            n_q                       <= 6'd0;
            FPU_Init_Req              <= 1'b0;
            BPU_Init_Req              <= 1'b0;
            Updata_BPUtail_beta       <= 1'b0;
            Updata_BPUtail_beta_delay <= 1'b0;
            Updata_BPU_beta           <= 1'b0;
            Updata_FPU_alpha          <= 1'b0;
            Updata_FPU_alpha_delay    <= 1'b0;
            win_idx                   <= 5'd0;
            busy                      <= 1'b0;
            done                      <= 1'b0;
        end else begin
            state_q                   <= state_d;
            tail_q                    <= tail_d;
            cyc_q                     <= cyc_d;
            win_q                     <= win_d;
            n_q                       <= n_d;
            FPU_Init_Req              <= fpu_init_d;
            BPU_Init_Req              <= bpu_init_d;
            Updata_BPUtail_beta       <= tail_beta_d;
            Updata_BPUtail_beta_delay <= tail_dly_d;
            Updata_BPU_beta           <= bpu_beta_d;
            Updata_FPU_alpha          <= fpu_alpha_d;
            Updata_FPU_alpha_delay    <= fin_d;
            win_idx                   <= win_out_d;
            busy                      <= (state_d != IDLE);
            done                      <= fin_d;
        end
    end

endmodule

// File: tb/tb_modu_init_ctrl.sv
// Randomized and directed bench for modu_init_ctrl against a
// cycle-offset reference model (WIN_LEN=8, TAIL_LEN=3).
module tb_modu_init_ctrl;

    localparam int W = 8;
    localparam int T = 3;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] q_up;
    logic       decMode;
    logic       FPU_Init_Req;
    logic       BPU_Init_Req;
    logic       Updata_BPUtail_beta;
    logic       Updata_BPUtail_beta_delay;
    logic       Updata_BPU_beta;
    logic       Updata_FPU_alpha;
    logic       Updata_FPU_alpha_delay;
    logic [4:0] win_idx;
    logic       busy;
    logic       done;

    modu_init_ctrl #(.WIN_LEN(W), .TAIL_LEN(T)) dut (
        .clk                      (clk),
        .rst                      (rst),
        .start                    (start),
        .q_up                     (q_up),
        .decMode                  (decMode),
        .FPU_Init_Req             (FPU_Init_Req),
        .BPU_Init_Req             (BPU_Init_Req),
        .Updata_BPUtail_beta      (Updata_BPUtail_beta),
        .Updata_BPUtail_beta_delay(Updata_BPUtail_beta_delay),
        .Updata_BPU_beta          (Updata_BPU_beta),
        .Updata_FPU_alpha         (Updata_FPU_alpha),
        .Updata_FPU_alpha_delay   (Updata_FPU_alpha_delay),
        .win_idx                  (win_idx),
        .busy                     (busy),
        .done                     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bit order: 13 FPU_Init, 12 BPU_Init, 11 tail, 10 tail_dly, 9 beta,
    // 8 alpha, 7 alpha_dly, 6:2 win_idx, 1 busy, 0 done.
    int          cyc;
    logic [13:0] act_v;
    logic [13:0] exp_v;
    bit          m_active;
    int          m_s;
    int          m_n;
    int          n_pass;
    int          n_total;

    function automatic int seq_end(input int n);
        return T + n * W + 1;
    endfunction

    function automatic bit model_idle(input int c);
        return !m_active || ((c - m_s) > seq_end(m_n));
    endfunction

    function automatic logic [13:0] model_exp(input int c);
        logic [13:0] v;
        int t, r, w, cc;
        bit inrun, beta;
        v = '0;
        if (!m_active) return v;
        t = c - m_s;
        if (t < 1 || t > seq_end(m_n)) return v;
        r     = t - T - 1;
        inrun = (r >= 0) && (r < m_n * W);
        w     = inrun ? r / W : 0;
        cc    = inrun ? r % W : 0;
        beta  = inrun && (cc == W - 1);
        v[13]  = inrun && (r == 0);
        v[12]  = inrun && (cc == 1);
        v[11]  = (t == T);
        v[10]  = beta && (w == 0);
        v[9]   = beta;
        v[8]   = beta && (w == m_n - 1);
        v[7]   = (t == seq_end(m_n));
        v[6:2] = 5'(w);
        v[1]   = 1'b1;
        v[0]   = (t == seq_end(m_n));
        return v;
    endfunction

    task automatic step(input bit st, input bit r, input logic [3:0] q, input bit dm);
        @(negedge clk);
        act_v = {FPU_Init_Req, BPU_Init_Req, Updata_BPUtail_beta,
                 Updata_BPUtail_beta_delay, Updata_BPU_beta, Updata_FPU_alpha,
                 Updata_FPU_alpha_delay, win_idx, busy, done};
        exp_v = model_exp(cyc);
        start   = st;
        rst     = r;
        q_up    = q;
        decMode = dm;
        if (r) begin
            m_active = 1'b0;
        end else if (st && model_idle(cyc)) begin
            m_active = 1'b1;
            m_s      = cyc;
            m_n      = dm ? 2 * (int'(q) + 1) : int'(q) + 1;
        end
        cyc++;
    endtask

    task automatic test_reset();
        step(0, 1, 4'd0, 0);
        step(1, 1, 4'd5, 1);
        step(0, 0, 4'd0, 0);
        n_total++;
        if (act_v !== 14'd0)
            $display("FAIL reset_outputs got=%h exp=%h", act_v, 14'd0);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 4'd0, 0);
            n_total++;
            if (act_v !== exp_v)
                $display("FAIL reset_idle off=%0d got=%h exp=%h", i, act_v, exp_v);
            else n_pass++;
        end
    endtask

    task automatic test_single();
        int tail_at, done_at, fi_at, bi_at, beta_at;
        tail_at = -1; done_at = -1; fi_at = -1; bi_at = -1; beta_at = -1;
        for (int i = 0; i < 16; i++) begin
            step(i == 0, 0, 4'd0, 0);
            n_total++;
            if (act_v !== exp_v)
                $display("FAIL single off=%0d got=%h exp=%h", i, act_v, exp_v);
            else n_pass++;
            if (act_v[11] && tail_at < 0) tail_at = i;
            if (act_v[13] && fi_at < 0) fi_at = i;
            if (act_v[12] && bi_at < 0) bi_at = i;
            if (act_v[9] && act_v[10] && act_v[8] && beta_at < 0) beta_at = i;
            if (act_v[0] && act_v[7] && done_at < 0) done_at = i;
        end
        n_total++;
        if (tail_at !== 3) $display("FAIL single_tail got=%0d exp=3", tail_at);
        else n_pass++;
        n_total++;
        if (fi_at !== 4) $display("FAIL single_fpu_init got=%0d exp=4", fi_at);
        else n_pass++;
        n_total++;
        if (bi_at !== 5) $display("FAIL single_bpu_init got=%0d exp=5", bi_at);
        else n_pass++;
        n_total++;
        if (beta_at !== 11) $display("FAIL single_beta got=%0d exp=11", beta_at);
        else n_pass++;
        n_total++;
        if (done_at !== 12) $display("FAIL single_done got=%0d exp=12", done_at);
        else n_pass++;
    endtask

    task automatic test_double8();
        int done_at, alpha_at, betas, maxw;
        done_at = -1; alpha_at = -1; betas = 0; maxw = 0;
        for (int i = 0; i < 72; i++) begin
            step(i == 0, 0, 4'd3, 1);
            n_total++;
            if (act_v !== exp_v)
                $display("FAIL double8 off=%0d got=%h exp=%h", i, act_v, exp_v);
            else n_pass++;
            if (act_v[9]) betas++;
            if (act_v[8] && alpha_at < 0) alpha_at = i;
            if (act_v[0] && done_at < 0) done_at = i;
            if (int'(act_v[6:2]) > maxw) maxw = int'(act_v[6:2]);
        end
        n_total++;
        if (betas !== 8) $display("FAIL double8_betas got=%0d exp=8", betas);
        else n_pass++;
        n_total++;
        if (alpha_at !== 67) $display("FAIL double8_alpha got=%0d exp=67", alpha_at);
        else n_pass++;
        n_total++;
        if (done_at !== 68) $display("FAIL double8_done got=%0d exp=68", done_at);
        else n_pass++;
        n_total++;
        if (maxw !== 7) $display("FAIL double8_win got=%0d exp=7", maxw);
        else n_pass++;
    endtask

    task automatic test_max();
        int done_at, maxw;
        done_at = -1; maxw = 0;
        for (int i = 0; i < 264; i++) begin
            step(i == 0, 0, 4'd15, 1);
            n_total++;
            if (act_v !== exp_v)
                $display("FAIL max32 off=%0d got=%h exp=%h", i, act_v, exp_v);
            else n_pass++;
            if (act_v[0] && done_at < 0) done_at = i;
            if (int'(act_v[6:2]) > maxw) maxw = int'(act_v[6:2]);
        end
        n_total++;
        if (done_at !== 260) $display("FAIL max32_done got=%0d exp=260", done_at);
        else n_pass++;
        n_total++;
        if (maxw !== 31) $display("FAIL max32_win got=%0d exp=31", maxw);
        else n_pass++;
    endtask

    task automatic test_ignored_start();
        int done_at, betas;
        done_at = -1; betas = 0;
        for (int i = 0; i < 72; i++) begin
            if (i == 0) step(1, 0, 4'd3, 1);
            else step(i == 6 || i == 20, 0, 4'($urandom_range(0, 15)), 1'($urandom));
            n_total++;
            if (act_v !== exp_v)
                $display("FAIL ignored off=%0d got=%h exp=%h", i, act_v, exp_v);
            else n_pass++;
            if (act_v[9]) betas++;
            if (act_v[0] && done_at < 0) done_at = i;
        end
        n_total++;
        if (done_at !== 68) $display("FAIL ignored_done got=%0d exp=68", done_at);
        else n_pass++;
        n_total++;
        if (betas !== 8) $display("FAIL ignored_betas got=%0d exp=8", betas);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int tail2;
        tail2 = -1;
        for (int i = 0; i < 30; i++) begin
            step(i == 0 || i == 12, i == 8, (i == 12) ? 4'd0 : 4'd3, i != 12);
            n_total++;
            if (act_v !== exp_v)
                $display("FAIL rstmid off=%0d got=%h exp=%h", i, act_v, exp_v);
            else n_pass++;
            if (i >= 9 && i <= 12) begin
                n_total++;
                if (act_v !== 14'd0)
                    $display("FAIL rstmid_quiet off=%0d got=%h exp=0", i, act_v);
                else n_pass++;
            end
            if (i > 12 && act_v[11] && tail2 < 0) tail2 = i;
        end
        n_total++;
        if (tail2 !== 15) $display("FAIL rstmid_tail got=%0d exp=15", tail2);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int d1, d2;
        d1 = -1; d2 = -1;
        for (int i = 0; i < 28; i++) begin
            step(i == 0 || i == 13, 0, 4'd0, 0);
            n_total++;
            if (act_v !== exp_v)
                $display("FAIL b2b off=%0d got=%h exp=%h", i, act_v, exp_v);
            else n_pass++;
            if (act_v[0]) begin
                if (d1 < 0) d1 = i;
                else if (d2 < 0) d2 = i;
            end
        end
        n_total++;
        if (d1 !== 12 || d2 !== 25)
            $display("FAIL b2b_done got=%0d,%0d exp=12,25", d1, d2);
        else n_pass++;
    endtask

    task automatic test_random();
        int len;
        logic [3:0] q;
        bit dm;
        for (int k = 0; k < 24; k++) begin
            q   = 4'($urandom_range(0, 15));
            dm  = 1'($urandom);
            len = seq_end(dm ? 2 * (int'(q) + 1) : int'(q) + 1) + int'($urandom_range(0, 4));
            for (int i = 0; i < len; i++) begin
                if (i == 0) step(1, 0, q, dm);
                else step($urandom_range(0, 15) == 0, $urandom_range(0, 299) == 0,
                          4'($urandom_range(0, 15)), 1'($urandom));
                n_total++;
                if (act_v !== exp_v)
                    $display("FAIL random it=%0d off=%0d got=%h exp=%h", k, i, act_v, exp_v);
                else n_pass++;
            end
        end
    endtask

    initial begin
        cyc      = 0;
        m_active = 1'b0;
        m_s      = 0;
        m_n      = 1;
        n_pass   = 0;
        n_total  = 0;
        rst      = 1'b1;
        start    = 1'b0;
        q_up     = 4'd0;
        decMode  = 1'b0;
        test_reset();
        test_single();
        test_double8();
        test_max();
        test_ignored_start();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/modu_init_ctrl.md
MODU_INIT_CTRL -- requirements
Module: modu_init_ctrl

Interface
REQ-001 SHALL have parameter WIN_LEN, default 32: cycles per sliding window, legal range 4..64.
REQ-002 SHALL have parameter TAIL_LEN, default 3: cycles of the tail-beta BPU pass, legal range 1..15.
REQ-003 SHALL have one clock and one reset: the clock is clk and the reset is rst, synchronous and active-high.
REQ-004 SHALL have port clk  input  1: rising-edge clock.
REQ-005 SHALL have port rst  input  1: synchronous active-high reset.
REQ-006 SHALL have port start  input  1: single-cycle half-iteration launch pulse.
REQ-007 SHALL have port q_up  input  4: window count minus one.
REQ-008 SHALL have port decMode  input  1: 1 = double-window mode.
REQ-009 SHALL have port FPU_Init_Req  output  1: alpha init read request pulse.
REQ-010 SHALL have port BPU_Init_Req  output  1: beta init read request pulse.
REQ-011 SHALL have port Updata_BPUtail_beta  output  1: tail beta capture strobe.
REQ-012 SHALL have port Updata_BPUtail_beta_delay  output  1: marks the first window's beta store.
REQ-013 SHALL have port Updata_BPU_beta  output  1: per-window beta store strobe.
REQ-014 SHALL have port Updata_FPU_alpha  output  1: final alpha capture strobe.
REQ-015 SHALL have port Updata_FPU_alpha_delay  output  1: alpha store strobe.
REQ-016 SHALL have port win_idx  output  5: current window index.
REQ-017 SHALL have port busy  output  1: half-iteration in progress.
REQ-018 SHALL have port done  output  1: completion pulse.

Function
REQ-019 SHALL latch q_up and decMode when start is accepted; later changes to these inputs SHALL have no effect until the next accepted start.
REQ-020 SHALL compute N = decMode ? 2*(q_up+1) : q_up+1 (range 1..32) in 6-bit arithmetic, with no truncation at 32.
REQ-021 SHALL implement states IDLE, TAIL, RUN, DRAIN: IDLE->TAIL on start; TAIL->RUN after TAIL_LEN cycles; RUN->DRAIN after the last cycle of window N-1; DRAIN->IDLE after 1 cycle.
REQ-022 SHALL accept start only in IDLE; start in any other state SHALL be ignored, with no restart and no counter disturbance.
REQ-023 SHALL use cycle-0 = the start cycle as the timing reference; TAIL SHALL occupy cycles 1..TAIL_LEN.
REQ-024 SHALL pulse Updata_BPUtail_beta on the last TAIL cycle (cycle TAIL_LEN).
REQ-025 SHALL, in RUN, count cyc_cnt 0..WIN_LEN-1 within each window, with win_idx advancing on each wrap; win_idx SHALL read 0 outside RUN.
REQ-026 SHALL pulse FPU_Init_Req only at cyc_cnt=0 of window 0, i.e. cycle TAIL_LEN+1.
REQ-027 SHALL pulse BPU_Init_Req at cyc_cnt=1 of every window, so it never coincides with FPU_Init_Req.
REQ-028 SHALL pulse Updata_BPU_beta at cyc_cnt=WIN_LEN-1 of every window.
REQ-029 SHALL assert Updata_BPUtail_beta_delay together with the window-0 Updata_BPU_beta only.
REQ-030 SHALL pulse Updata_FPU_alpha together with the Updata_BPU_beta of window N-1.
REQ-031 SHALL assert Updata_FPU_alpha_delay and done in DRAIN, one cycle after Updata_FPU_alpha, and never together with Updata_BPU_beta.
REQ-032 SHALL hold busy high in TAIL, RUN and DRAIN, and low in IDLE.
REQ-033 SHALL accept a new start on the cycle after done.
REQ-034 SHALL register every output, with no combinational path from any input to any output.

Reset
REQ-035 SHALL, on rst, force IDLE, clear all counters and latched values, and drive every output to 0 on the following edge.
REQ-036 SHALL, on rst mid-operation, emit no further strobes; rst SHALL take precedence over a simultaneous start.

Verification (WIN_LEN=8, TAIL_LEN=3)
REQ-037 SHALL cover: q_up=0, decMode=0, start @0 -> tail strobe @3, FPU_Init @4, BPU_Init @5, BPU_beta + tail_delay + FPU_alpha @11, alpha_delay + done @12, busy 1..12.
REQ-038 SHALL cover: q_up=3, decMode=1 -> N=8, BPU_Init @5,13,..,61, BPU_beta @11,19,..,67, FPU_alpha @67, done @68, win_idx steps 0..7.
REQ-039 SHALL cover: q_up=15, decMode=1 -> N=32, win_idx reaches 31 with no wrap, done @260.
REQ-040 SHALL cover: start pulsed @6 and @20 during the run from REQ-037/REQ-038 -> ignored, strobe timing unchanged.
REQ-041 SHALL cover: rst @8 of the REQ-038 run -> all outputs 0 from @9, no further strobes; start @12 -> new sequence with tail strobe @15.
REQ-042 SHALL cover: start on the cycle after done -> accepted, second sequence timing identical to the first shifted by 13 cycles (REQ-037 case).
